// File: rtl/spu_issuer.sv
// TinySPU host-side issuer: registers commands onto the SPU input bus, tracks them
// through the SPU's fixed latency and buffers M/N results in a fall-through FIFO.
module spu_issuer #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [3:0] cmd_c,
  input  logic [3:0] cmd_d,
  output logic [3:0] spu_op,
  output logic [3:0] spu_a,
  output logic [3:0] spu_b,
  output logic [3:0] spu_c,
  output logic [3:0] spu_d,
  input  logic [3:0] spu_m,
  input  logic [3:0] spu_n,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_op,
  output logic [3:0] rsp_m,
  output logic [3:0] rsp_n,
  output logic       busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] m;
    logic [3:0] n;
  } rsp_t;

  logic [3:0] spu_op_q, spu_op_d;
  logic [3:0] spu_a_q, spu_a_d, spu_b_q, spu_b_d;
  logic [3:0] spu_c_q, spu_c_d, spu_d_q, spu_d_d;

  logic [LATENCY:0]      vld_pipe_q, vld_pipe_d;
  logic [LATENCY:0][3:0] op_pipe_q, op_pipe_d;

  rsp_t [DEPTH-1:0] mem_q, mem_d;
  rsp_t             hold_q, hold_d, head;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occ;

  logic [4:0] inflight, credit;
  logic       hs, push, pop, empty, full;

  assign occ   = wr_ptr_q - rd_ptr_q;
  assign empty = (occ == '0);
  assign full  = (occ == PW'(DEPTH));
  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign pop   = !empty && rsp_ready;
  // full+push cannot happen thanks to the credit check; the pop term keeps it safe anyway
  assign push  = vld_pipe_q[LATENCY] && (!full || pop);

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= LATENCY; i++) inflight = inflight + 5'(vld_pipe_q[i]);
  end

  // Conservative credit: a same-cycle pop is not counted
  assign credit    = inflight + 5'(occ);
  assign cmd_ready = rst_n && (credit < 5'(DEPTH));
  assign hs        = cmd_valid && cmd_ready;

  always_comb begin
    spu_op_d   = hs ? cmd_op : 4'd0;
    spu_a_d    = hs ? cmd_a : spu_a_q;
    spu_b_d    = hs ? cmd_b : spu_b_q;
    spu_c_d    = hs ? cmd_c : spu_c_q;
    spu_d_d    = hs ? cmd_d : spu_d_q;
    vld_pipe_d = {vld_pipe_q[LATENCY-1:0], hs};
    op_pipe_d  = {op_pipe_q[LATENCY-1:0], (hs ? cmd_op : 4'd0)};
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    hold_d   = hold_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = {op_pipe_q[LATENCY], spu_m, spu_n};
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      hold_d   = head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spu_op_q   <= '0;
      spu_a_q    <= '0;
      spu_b_q    <= '0;
      spu_c_q    <= '0;
      spu_d_q    <= '0;
      vld_pipe_q <= '0;
      op_pipe_q  <= '0;
      mem_q      <= '0;
      hold_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      spu_op_q   <= spu_op_d;
      spu_a_q    <= spu_a_d;
      spu_b_q    <= spu_b_d;
      spu_c_q    <= spu_c_d;
      spu_d_q    <= spu_d_d;
      vld_pipe_q <= vld_pipe_d;
      op_pipe_q  <= op_pipe_d;
      mem_q      <= mem_d;
      hold_q     <= hold_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  assign spu_op    = spu_op_q;
  assign spu_a     = spu_a_q;
  assign spu_b     = spu_b_q;
  assign spu_c     = spu_c_q;
  assign spu_d     = spu_d_q;
  assign rsp_valid = !empty;
  // Empty FIFO shows the last popped entry
  assign {rsp_op, rsp_m, rsp_n} = empty ? hold_q : head;
  assign busy      = (inflight != '0) || !empty;

endmodule

// File: tb/tb_spu_issuer.sv
// Scoreboard bench for spu_issuer with a 2-stage A+B / C^D SPU model.
module tb_spu_issuer;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [3:0] cmd_op = '0, cmd_a = '0, cmd_b = '0, cmd_c = '0, cmd_d = '0;
  logic [3:0] spu_op, spu_a, spu_b, spu_c, spu_d, spu_m, spu_n;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [3:0] rsp_op, rsp_m, rsp_n;
  logic       busy;

  always #5 clk = ~clk;

  spu_issuer #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_d(cmd_d),
    .spu_op(spu_op), .spu_a(spu_a), .spu_b(spu_b), .spu_c(spu_c), .spu_d(spu_d),
    .spu_m(spu_m), .spu_n(spu_n),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_op(rsp_op), .rsp_m(rsp_m), .rsp_n(rsp_n),
    .busy(busy)
  );

  // SPU model: two register stages, M = A+B, N = C^D
  logic [3:0] s1_m = '0, s1_n = '0, s2_m = '0, s2_n = '0;
  always @(posedge clk) begin
    s1_m <= spu_a + spu_b;
    s1_n <= spu_c ^ spu_d;
    s2_m <= s1_m;
    s2_n <= s1_n;
  end
  assign spu_m = s2_m;
  assign spu_n = s2_n;

  typedef struct {
    logic [3:0] op;
    logic [3:0] m;
    logic [3:0] n;
    int         ready_at;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   pass_cnt = 0, tot_cnt = 0;
  bit   rdy_rand = 1'b0;
  bit   ovf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endfunction

  // Monitor: outstanding = accepted - popped; drives every per-cycle expectation
  always @(negedge clk) begin
    if (rst_n) begin
      int  n;
      bit  vexp;
      n = sb.size();
      vexp = 1'b0;
      if (n > 0) vexp = (sb[0].ready_at <= cyc);
      if (n > DEPTH) ovf = 1'b1;
      chk("cmd_ready", int'(cmd_ready), int'(n < DEPTH));
      chk("busy", int'(busy), int'(n != 0));
      chk("rsp_valid", int'(rsp_valid), int'(vexp));
      if (rsp_valid && rsp_ready && n > 0) begin
        chk("rsp_op", int'(rsp_op), int'(sb[0].op));
        chk("rsp_m", int'(rsp_m), int'(sb[0].m));
        chk("rsp_n", int'(rsp_n), int'(sb[0].n));
        void'(sb.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rdy_rand) rsp_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [3:0] op, a, b, c, d);
    bit hs;
    int ra;
    int tries;
    exp_t e;
    tries = 0;
    cmd_valid = 1'b1;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_c = c; cmd_d = d;
    do begin
      @(negedge clk);
      hs = cmd_ready;
      ra = cyc + LATENCY + 2;
      @(posedge clk);
      if (hs) begin
        e.op = op; e.m = 4'(a + b); e.n = c ^ d; e.ready_at = ra;
        sb.push_back(e);
      end
      #1;
      tries++;
    end while (!hs && tries < 200);
    if (!hs) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    cmd_valid = 1'b0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    int cnt;
    #1;
    chk("ready_in_reset", int'(cmd_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_spu_op", int'(spu_op), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rsp_op", int'(rsp_op), 0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;

    // single command
    send(4'd5, 4'd3, 4'd4, 4'd9, 4'd6);
    chk("issue_op", int'(spu_op), 5);
    chk("issue_a", int'(spu_a), 3);
    chk("issue_b", int'(spu_b), 4);
    chk("issue_c", int'(spu_c), 9);
    chk("issue_d", int'(spu_d), 6);
    drain();

    // back-to-back A=i, B=1
    for (int i = 0; i < 8; i++) send(4'(i + 1), 4'(i), 4'd1, 4'(i), 4'd5);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_nop", int'(spu_op), 0);
    chk("idle_hold_a", int'(spu_a), 7);
    drain();

    // back-pressure: exactly DEPTH handshakes
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(4'd2, 4'(i), 4'd2, 4'd1, 4'(i));
    cmd_op = 4'd6; cmd_a = 4'd1; cmd_b = 4'd1; cmd_c = 4'd0; cmd_d = 4'd0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (cmd_ready) cnt++;
    end
    chk("extra_handshakes", cnt, 0);
    chk("full_busy", int'(busy), 1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    send(4'd6, 4'd1, 4'd1, 4'd0, 4'd0);
    drain();

    // opcode pass-through 9,3,9
    send(4'd9, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    send(4'd3, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    send(4'd9, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    drain();

    // random traffic with random back-pressure, wraps the pointers
    rdy_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        cmd_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    rdy_rand = 1'b0;
    rsp_ready = 1'b1;
    drain();

    // reset with 2 buffered and 2 in flight
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'(i + 1), 4'd5, 4'(i), 4'd3, 4'd12);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_spu_a", int'(spu_a), 0);
    chk("mid_rst_spu_c", int'(spu_c), 0);
    chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
    chk("mid_rst_rsp_op", int'(rsp_op), 0);
    chk("mid_rst_rsp_m", int'(rsp_m), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(cmd_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    chk("post_rst_busy", int'(busy), 0);
    send(4'd7, 4'd2, 4'd2, 4'd15, 4'd1);
    drain();

    chk("no_overflow", int'(ovf), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
